// File: rtl/sram_stream_reader.sv
// Streams a contiguous burst of words from SRAM read port 1 as a valid/ready stream.
// Reads are credit-limited so every issued read always has a free FIFO slot on capture.
module sram_stream_reader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] dout1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  done
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OccW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q;
    logic [ADDR_WIDTH:0]   remaining_q;
    logic                  inflight_q, inflight_last_q;
    logic                  done_zero_q, done_zero_d;

    logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic                  last_mem [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [OccW-1:0]       occ_q;

    logic issue, push, pop, credit_ok, final_issue;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Registered occupancy only, so out_ready never reaches csb1 combinationally.
    assign credit_ok   = ({1'b0, occ_q} + {{OccW{1'b0}}, inflight_q}) < (OccW + 1)'(FIFO_DEPTH);
    assign final_issue = issue && (remaining_q == (ADDR_WIDTH + 1)'(1));

    assign push      = inflight_q;
    assign out_valid = (occ_q != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? data_mem[rd_ptr_q] : '0;
    assign out_last  = out_valid && last_mem[rd_ptr_q];
    assign done      = done_zero_q || (pop && out_last);

    assign csb1  = !issue;
    assign addr1 = issue ? cur_addr_q : '0;

    always_comb begin
        state_d     = state_q;
        cmd_ready   = 1'b0;
        issue       = 1'b0;
        done_zero_d = 1'b0;
        case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_len != '0) state_d = StIssue;
                    else               done_zero_d = 1'b1;
                end
            end
            StIssue: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (remaining_q == (ADDR_WIDTH + 1)'(1)) state_d = StDrain;
                end
            end
            StDrain: begin
                // The tagged-last beat is always the final FIFO entry of the burst.
                if (pop && out_last) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            cur_addr_q      <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_zero_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            inflight_q      <= issue;
            inflight_last_q <= final_issue;
            done_zero_q     <= done_zero_d;
            if (state_q == StIdle && cmd_valid && cmd_len != '0) begin
                cur_addr_q  <= cmd_addr;
                remaining_q <= cmd_len;
            end else if (issue) begin
                cur_addr_q  <= cur_addr_q + 1'b1;
                remaining_q <= remaining_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                data_mem[i] <= '0;
                last_mem[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                data_mem[wr_ptr_q] <= dout1;
                last_mem[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q           <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_stream_reader.sv
// Directed bench for sram_stream_reader with an SRAM model and an address/data scoreboard.
module tb_sram_stream_reader;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [AW:0]   cmd_len;
    logic          csb1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] dout1;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          done;

    sram_stream_reader #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .csb1      (csb1),
        .addr1     (addr1),
        .dout1     (dout1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [1024];
    always @(posedge clk) dout1 <= csb1 ? 'x : mem[addr1];

    int checks = 0;
    int errors = 0;
    logic [DW:0]   exp_data [$];
    logic [AW-1:0] exp_addr [$];
    int issue_cnt = 0, beat_cnt = 0, done_cnt = 0, valid_cnt = 0, last_cnt = 0;
    int outstanding = 0;
    logic rand_en = 1'b0;
    logic hold_q = 1'b0;
    logic [DW-1:0] hold_data;
    logic hold_last;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) if (rand_en) begin
        #1 out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: scoreboard pops, credit bound and hold-stability.
    always @(negedge clk) begin
        logic [DW:0]   e;
        logic [AW-1:0] a;
        if (!rst_n) begin
            hold_q = 1'b0;
        end else begin
            if (hold_q) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'(out_data), 64'(hold_data));
                check("hold_last", 64'(out_last), 64'(hold_last));
            end
            if (!csb1) begin
                issue_cnt++;
                outstanding++;
                if (exp_addr.size() == 0) check("unexpected_issue", 64'd1, 64'd0);
                else begin
                    a = exp_addr.pop_front();
                    check("addr1", 64'(addr1), 64'(a));
                end
                if (outstanding > DEPTH) check("credit_bound", 64'(outstanding), 64'(DEPTH));
            end
            if (out_valid) begin
                valid_cnt++;
                if ($isunknown(out_data)) check("out_data_x", 64'd1, 64'd0);
            end
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                beat_cnt++;
                outstanding--;
                if (out_last) last_cnt++;
                if (exp_data.size() == 0) check("unexpected_beat", 64'd1, 64'd0);
                else begin
                    e = exp_data.pop_front();
                    check("out_data", 64'(out_data), 64'(e[DW-1:0]));
                    check("out_last", 64'(out_last), 64'(e[DW]));
                    check("done_on_beat", 64'(done), 64'(e[DW]));
                end
            end
            hold_q    = out_valid && !out_ready;
            hold_data = out_data;
            hold_last = out_last;
        end
    end

    task automatic send_cmd(input logic [AW-1:0] a, input int len);
        logic [AW-1:0] ai;
        @(posedge clk); #1;
        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = (AW + 1)'(len);
        for (int i = 0; i < len; i++) begin
            ai = a + AW'(i);
            exp_addr.push_back(ai);
            exp_data.push_back({(i == len - 1), mem[ai]});
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0, input int budget);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check({tag, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
        repeat (3) @(negedge clk);
        #1;
        check({tag, "_done_once"}, 64'(done_cnt), 64'(d0 + 1));
        check({tag, "_queue_empty"}, 64'(exp_data.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_csb1"}, 64'(csb1), 64'd1);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, "_addr1"}, 64'(addr1), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_data"}, 64'(out_data), 64'd0);
        check({tag, "_out_last"}, 64'(out_last), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, b0, i0, v0, l0, n;
        for (int i = 0; i < 1024; i++) mem[i] = DW'(i);
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        out_ready = 1'b1;
        #1;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic burst plus first-beat latency.
        d0 = done_cnt; b0 = beat_cnt;
        send_cmd(10'd5, 4);
        @(negedge clk); check("lat_c1_valid", 64'(out_valid), 64'd0);
        @(negedge clk); check("lat_c2_valid", 64'(out_valid), 64'd0);
        @(negedge clk); check("lat_c3_valid", 64'(out_valid), 64'd1);
        wait_done("basic", d0, 200);
        check("basic_beats", 64'(beat_cnt - b0), 64'd4);

        // Wrap across the top of the array.
        d0 = done_cnt; b0 = beat_cnt;
        send_cmd(10'd1022, 4);
        wait_done("wrap", d0, 200);
        check("wrap_beats", 64'(beat_cnt - b0), 64'd4);

        // Downstream stall mid-burst.
        d0 = done_cnt; b0 = beat_cnt;
        send_cmd(10'd200, 8);
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(negedge clk);
        check("stall_csb1_high", 64'(csb1), 64'd1);
        check("stall_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1 out_ready = 1'b1;
        wait_done("stall", d0, 200);
        check("stall_beats", 64'(beat_cnt - b0), 64'd8);

        // Zero-length command.
        d0 = done_cnt; i0 = issue_cnt; v0 = valid_cnt;
        send_cmd(10'd77, 0);
        repeat (4) begin
            @(negedge clk);
            check("zero_cmd_ready", 64'(cmd_ready), 64'd1);
        end
        check("zero_done_once", 64'(done_cnt), 64'(d0 + 1));
        check("zero_no_issue", 64'(issue_cnt), 64'(i0));
        check("zero_no_valid", 64'(valid_cnt), 64'(v0));

        // Reset in the middle of a burst.
        d0 = done_cnt; b0 = beat_cnt;
        send_cmd(10'd300, 16);
        n = 0;
        while (beat_cnt - b0 < 3 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        check("rst_three_beats", 64'(beat_cnt - b0), 64'd3);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_data.delete();
        exp_addr.delete();
        outstanding = 0;
        repeat (2) @(negedge clk);
        check_reset_outputs("midrst_hold");
        check("midrst_no_done", 64'(done_cnt), 64'(d0));
        @(posedge clk); #1 rst_n = 1'b1;
        d0 = done_cnt; b0 = beat_cnt;
        send_cmd(10'd0, 2);
        wait_done("post_rst", d0, 200);
        check("post_rst_beats", 64'(beat_cnt - b0), 64'd2);

        // Full array with random backpressure.
        d0 = done_cnt; b0 = beat_cnt; l0 = last_cnt;
        rand_en = 1'b1;
        send_cmd(10'd512, 1024);
        wait_done("full", d0, 20000);
        rand_en = 1'b0;
        @(posedge clk); #2 out_ready = 1'b1;
        check("full_beats", 64'(beat_cnt - b0), 64'd1024);
        check("full_one_last", 64'(last_cnt - l0), 64'd1);
        check("full_idle_ready", 64'(cmd_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
